// File: rtl/clk_div_gen_if.sv
// rtl/clk_div_gen_if.sv - control and status bundle for clk_div_gen
interface clk_div_gen_if #(
  parameter int WIDTH = 17
);
  logic             enable;
  logic             div_load;
  logic [WIDTH-1:0] div_value;
  logic             div_clock;
  logic             tick;
  logic             load_pending;
  logic             load_err;

  modport master (
    output enable,
    output div_load,
    output div_value,
    input  div_clock,
    input  tick,
    input  load_pending,
    input  load_err
  );

  modport slave (
    input  enable,
    input  div_load,
    input  div_value,
    output div_clock,
    output tick,
    output load_pending,
    output load_err
  );
endinterface

// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - 50% duty clock divider with glitch-free half-period reload
// Optional tick output is built only when CLK_DIV_GEN_TICK_EN is defined.
module clk_div_gen #(
  parameter int WIDTH     = 17,
  parameter int RESET_DIV = 100000
) (
  input logic          clock,
  input logic          reset,
  clk_div_gen_if.slave bus
);
  localparam logic [WIDTH-1:0] RESET_HP = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] hp_q, hp_d;
  logic [WIDTH-1:0] nxt_q, nxt_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             div_clk_q, div_clk_d;
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic             boundary;
  logic             load_ok;
  logic             load_bad;

  assign load_ok  = bus.div_load && (bus.div_value != '0);
  assign load_bad = bus.div_load && (bus.div_value == '0);
  assign boundary = bus.enable && (cnt_q == hp_q - ONE);

  always_comb begin
    hp_d      = hp_q;
    nxt_d     = nxt_q;
    cnt_d     = cnt_q;
    div_clk_d = div_clk_q;
    pend_d    = pend_q;
    err_d     = load_bad;
    if (bus.enable) begin
      if (boundary) begin
        cnt_d     = '0;
        div_clk_d = ~div_clk_q;
        // A new half-period only ever starts at a phase edge, so no short phase.
        if (pend_q) begin
          hp_d   = nxt_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else if (pend_q) begin
      hp_d   = nxt_q;
      cnt_d  = '0;
      pend_d = 1'b0;
    end
    // A load landing on a boundary is queued behind the value applied there.
    if (load_ok) begin
      nxt_d  = bus.div_value;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      hp_q      <= RESET_HP;
      nxt_q     <= RESET_HP;
      cnt_q     <= '0;
      div_clk_q <= 1'b0;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      hp_q      <= hp_d;
      nxt_q     <= nxt_d;
      cnt_q     <= cnt_d;
      div_clk_q <= div_clk_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
    end
  end

`ifdef CLK_DIV_GEN_TICK_EN
  logic tick_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= boundary;
    end
  end

  assign bus.tick = tick_q;
`else
  assign bus.tick = 1'b0;
`endif

  assign bus.div_clock    = div_clk_q;
  assign bus.load_pending = pend_q;
  assign bus.load_err     = err_q;
endmodule

// File: tb/tb_clk_div_gen.sv
// tb/tb_clk_div_gen.sv - directed and random checks of clk_div_gen against a phase-length model
module tb_clk_div_gen;
  localparam int W  = 17;
  localparam int RD = 4;

  logic clock;
  logic reset;
  int   tests_run;
  int   tests_failed;

  // Model: length of the current phase, cycles spent in it, queued length.
  int   m_half;
  int   m_queued;
  int   m_has_queued;
  int   m_elapsed;
  int   m_clk;
  int   m_tick;
  int   m_err;

  clk_div_gen_if #(.WIDTH(W)) bus ();

  clk_div_gen #(
    .WIDTH    (W),
    .RESET_DIV(RD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input longint got, input longint exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic en, input logic ld, input int val);
    if (!rst) begin
      m_half = RD; m_queued = RD; m_has_queued = 0;
      m_elapsed = 0; m_clk = 0; m_tick = 0; m_err = 0;
    end else begin
      m_err  = (ld && val == 0) ? 1 : 0;
      m_tick = 0;
      if (en) begin
        m_elapsed = m_elapsed + 1;
        if (m_elapsed == m_half) begin
          m_clk = 1 - m_clk;
          m_tick = 1;
          m_elapsed = 0;
          if (m_has_queued != 0) begin
            m_half = m_queued;
            m_has_queued = 0;
          end
        end
      end else if (m_has_queued != 0) begin
        m_half = m_queued;
        m_has_queued = 0;
        m_elapsed = 0;
      end
      if (ld && val != 0) begin
        m_queued = val;
        m_has_queued = 1;
      end
    end
  endtask

  task automatic cycle(input logic rst, input logic en, input logic ld, input int val);
    int exp_tick;
    reset = rst;
    bus.enable = en;
    bus.div_load = ld;
    bus.div_value = W'(val);
    @(posedge clock);
    model_step(rst, en, ld, val);
    #1;
`ifdef CLK_DIV_GEN_TICK_EN
    exp_tick = m_tick;
`else
    exp_tick = 0;
`endif
    check("div_clock", bus.div_clock, m_clk);
    check("tick", bus.tick, exp_tick);
    check("load_pending", bus.load_pending, m_has_queued);
    check("load_err", bus.load_err, m_err);
  endtask

  task automatic wait_toggle(input int limit, output int n);
    logic start;
    start = bus.div_clock;
    n = 0;
    do begin
      cycle(1'b1, 1'b1, 1'b0, 0);
      n++;
    end while (bus.div_clock == start && n < limit);
    if (bus.div_clock == start) check("toggle_in_bound", 0, 1);
  endtask

  initial begin
    int   n;
    logic prev;
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b0;
    bus.enable = 1'b0;
    bus.div_load = 1'b0;
    bus.div_value = '0;

    cycle(1'b0, 1'b1, 1'b1, 3);
    cycle(1'b0, 1'b1, 1'b0, 0);
    check("reset_div_clock", bus.div_clock, 0);
    check("reset_pending", bus.load_pending, 0);

    // Reset half-period: toggles every 4 cycles.
    wait_toggle(50, n); check("first_toggle", n, 4);
    wait_toggle(50, n); check("second_toggle", n, 4);
    wait_toggle(50, n); check("third_toggle", n, 4);

    // Load 2 while cnt=1 under hp=4.
    cycle(1'b1, 1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b1, 2);
    check("pending_after_load", bus.load_pending, 1);
    wait_toggle(50, n); check("load2_boundary", n, 2);
    check("pending_cleared", bus.load_pending, 0);
    wait_toggle(50, n); check("hp2_period_a", n, 2);
    wait_toggle(50, n); check("hp2_period_b", n, 2);

    // Rejected zero load.
    cycle(1'b1, 1'b1, 1'b1, 0);
    check("load_err_pulse", bus.load_err, 1);
    cycle(1'b1, 1'b1, 1'b0, 0);
    check("load_err_single", bus.load_err, 0);
    wait_toggle(50, n); check("period_after_err", n, 2);

    // Restore hp=4, then freeze at cnt=2 for 10 cycles.
    cycle(1'b1, 1'b1, 1'b1, 4);
    wait_toggle(50, n);
    wait_toggle(50, n); check("hp4_restored", n, 4);
    cycle(1'b1, 1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b0, 0);
    prev = bus.div_clock;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 0);
    check("frozen_clock", bus.div_clock, prev);
    wait_toggle(50, n); check("resume_toggle", n, 2);

    // Back-to-back loads 6 then 3, then a load of 1 on a boundary.
    cycle(1'b1, 1'b1, 1'b1, 6);
    cycle(1'b1, 1'b1, 1'b1, 3);
    wait_toggle(50, n); check("b2b_boundary", n, 2);
    cycle(1'b1, 1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b0, 0);
    prev = bus.div_clock;
    cycle(1'b1, 1'b1, 1'b1, 1);
    check("boundary_load_toggle", bus.div_clock, !prev);
    wait_toggle(50, n); check("hp3_period", n, 3);
    wait_toggle(50, n); check("hp1_period_a", n, 1);
    wait_toggle(50, n); check("hp1_period_b", n, 1);

    // Reset discards a pending load.
    cycle(1'b1, 1'b1, 1'b1, 7);
    cycle(1'b0, 1'b1, 1'b0, 0);
    check("rst_div_clock", bus.div_clock, 0);
    check("rst_pending", bus.load_pending, 0);
    check("rst_err", bus.load_err, 0);
    wait_toggle(50, n); check("post_rst_toggle", n, RD);
    wait_toggle(50, n); check("pending_discarded", n, RD);

    // Load applied while disabled.
    cycle(1'b1, 1'b0, 1'b1, 5);
    cycle(1'b1, 1'b0, 1'b0, 0);
    check("disabled_apply", bus.load_pending, 0);
    wait_toggle(50, n); check("disabled_apply_period", n, 5);

    for (int i = 0; i < 3000; i++) begin
      logic r_rst, r_en, r_ld;
      int   r_val;
      r_rst = ($urandom_range(99) != 0);
      r_en  = ($urandom_range(9) < 8);
      r_ld  = ($urandom_range(99) < 12);
      r_val = $urandom_range(7);
      cycle(r_rst, r_en, r_ld, r_val);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 The module SHALL have parameter WIDTH, default 17: bit width of the half-period counter and of div_value.
REQ-002 The module SHALL have parameter RESET_DIV, default 100000: half-period in clock cycles loaded at reset; legal range 1 to 2^WIDTH-1.
REQ-003 The module SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The module SHALL have port enable, input, 1 bit: high to count, low to freeze.
REQ-006 The module SHALL have port div_load, input, 1 bit: one-cycle request to load a new half-period.
REQ-007 The module SHALL have port div_value, input, WIDTH bits: requested half-period, sampled only when div_load=1.
REQ-008 The module SHALL have port div_clock, output, 1 bit: registered divided clock, period 2*hp cycles, 50% duty.
REQ-009 The module SHALL have port tick, output, 1 bit: registered one-cycle pulse per div_clock toggle.
REQ-010 The module SHALL have port load_pending, output, 1 bit: accepted load waiting for the next toggle boundary.
REQ-011 The module SHALL have port load_err, output, 1 bit: registered one-cycle pulse when a load is rejected.

Function
REQ-012 Internal state SHALL be: active half-period hp, pending half-period nxt, counter cnt (all WIDTH bits), div_clock, load_pending.
REQ-013 With enable=1, cnt SHALL increment each cycle; at cnt==hp-1 (the "boundary"), cnt SHALL return to 0 and div_clock SHALL invert in the same cycle.
REQ-014 The first toggle after reset or after a load takes effect SHALL occur hp cycles later; each subsequent toggle SHALL occur every hp cycles.
REQ-015 hp=1 SHALL toggle div_clock every cycle (divide by 2).
REQ-016 With enable=0, cnt, hp and div_clock SHALL hold; tick SHALL be 0; on re-enable, counting SHALL resume from the held cnt.
REQ-017 div_load=1 with div_value=0 SHALL be rejected: load_err=1 on the next cycle; hp, nxt and load_pending unchanged.
REQ-018 div_load=1 with div_value!=0 SHALL set nxt=div_value and load_pending=1 on the next cycle.
REQ-019 A pending nxt SHALL be copied to hp at the next boundary, together with clearing load_pending; div_clock SHALL never produce a high or low phase shorter than min(old hp, new hp).
REQ-020 With enable=0 and load_pending=1, nxt SHALL be copied to hp on the following cycle, cnt cleared to 0, div_clock held.
REQ-021 A new accepted load while load_pending=1 SHALL overwrite nxt; only the latest value is applied.
REQ-022 A load arriving in the same cycle as a boundary SHALL not affect that boundary; it is applied at the following boundary.
REQ-023 If hp is reduced below the current cnt+1 by a load, no effect SHALL occur before the boundary, because the load applies only at the boundary, so cnt never exceeds hp-1.
REQ-024 cnt arithmetic SHALL be unsigned WIDTH-bit arithmetic without overflow; the maximum half-period is 2^WIDTH-1.

Reset
REQ-025 reset=0 at a clock edge SHALL set hp=RESET_DIV, nxt=RESET_DIV, cnt=0, div_clock=0, tick=0, load_pending=0, load_err=0.
REQ-026 reset SHALL take priority over enable and div_load; a pending load SHALL be discarded by reset mid-operation.
REQ-027 The first boundary after reset release SHALL occur RESET_DIV cycles after the first cycle with reset=1 and enable=1.

Configuration
REQ-028 Macro CLK_DIV_GEN_TICK_EN defined: tick SHALL be driven per REQ-009, asserted in the same cycle as each div_clock transition.
REQ-029 Macro CLK_DIV_GEN_TICK_EN undefined: tick SHALL be tied to constant 0 with no tick register; all other behaviour is unchanged.

Verification
REQ-030 The bench SHALL cover RESET_DIV=4 with enable held at 1: div_clock toggles at cycles 4, 8, 12, and so on after reset release; period 8; tick pulses at the same cycles (with the macro defined).
REQ-031 The bench SHALL cover div_load with div_value=2 at cnt=1 while hp=4: load_pending=1 until the boundary 3 cycles later, then toggles occur every 2 cycles.
REQ-032 The bench SHALL cover div_load with div_value=0: load_err pulses for exactly 1 cycle; hp and the div_clock period are unchanged.
REQ-033 The bench SHALL cover enable=0 for 10 cycles at cnt=2, hp=4: div_clock frozen, tick=0; after re-enable, the next toggle occurs 2 cycles later.
REQ-034 The bench SHALL cover back-to-back loads of 6 then 3 before a boundary, then a load of 1 coinciding with a boundary: hp=3 after the first boundary, hp=1 after the next.
REQ-035 The bench SHALL cover reset=0 asserted while load_pending=1: all outputs are 0 the next cycle; hp returns to RESET_DIV; the pending value is never applied.
